// File: rtl/proc_dmem_mmio_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO block
// with output registers, sampled input ports, a cycle counter and an error counter.
module proc_dmem_mmio_responder #(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        rst,
  // One request per cycle and no ready: a request is accepted when
  // dmemreq_val=1. Read data and the error flag answer it in the same cycle,
  // and any state change it causes happens at the next rising edge.
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  output logic        dmemresp_err,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] mem_q [RAM_WORDS];
  logic [31:0] out0_q, out1_q, out2_q;
  logic [31:0] in0_q, in1_q, in2_q;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] errc_q, errc_d;

  logic        aligned, in_ram, in_mmio;
  logic [5:0]  off;
  logic [31:0] rdata;
  logic        err;
  logic        ram_we, out0_we, out1_we, out2_we, cyc_clr, errc_clr;

  always_comb begin
    aligned  = (dmemreq_addr[1:0] == 2'b00);
    in_ram   = (dmemreq_addr[31:AW+2] == '0);
    in_mmio  = (dmemreq_addr[31:6] == MMIO_BASE[31:6]);
    off      = dmemreq_addr[5:0];
    rdata    = 32'h0;
    err      = 1'b0;
    ram_we   = 1'b0;
    out0_we  = 1'b0;
    out1_we  = 1'b0;
    out2_we  = 1'b0;
    cyc_clr  = 1'b0;
    errc_clr = 1'b0;
    if (dmemreq_val) begin
      if (!aligned) begin
        err = 1'b1;
      end else if (in_ram) begin
        rdata  = mem_q[dmemreq_addr[AW+1:2]];
        ram_we = dmemreq_type;
      end else if (in_mmio) begin
        case (off)
          6'h00: begin rdata = out0_q; out0_we = dmemreq_type; end
          6'h04: begin rdata = out1_q; out1_we = dmemreq_type; end
          6'h08: begin rdata = out2_q; out2_we = dmemreq_type; end
          6'h10: begin if (dmemreq_type) err = 1'b1; else rdata = in0_q; end
          6'h14: begin if (dmemreq_type) err = 1'b1; else rdata = in1_q; end
          6'h18: begin if (dmemreq_type) err = 1'b1; else rdata = in2_q; end
          6'h20: begin rdata = cyc_q;  cyc_clr  = dmemreq_type; end
          6'h24: begin rdata = errc_q; errc_clr = dmemreq_type; end
          default: err = 1'b1;
        endcase
      end else begin
        err = 1'b1;
      end
    end
  end

  assign dmemresp_rdata = rdata;
  assign dmemresp_err   = err;
  assign out0 = out0_q;
  assign out1 = out1_q;
  assign out2 = out2_q;

  // A clear write lands as 0 after the edge and wins over any increment.
  always_comb begin
    cyc_d  = cyc_clr ? 32'h0 : cyc_q + 32'h1;
    errc_d = errc_q;
    if (errc_clr)
      errc_d = 32'h0;
    else if (err && errc_q != 32'hFFFF_FFFF)
      errc_d = errc_q + 32'h1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_q <= 32'h0;
      out1_q <= 32'h0;
      out2_q <= 32'h0;
      in0_q  <= 32'h0;
      in1_q  <= 32'h0;
      in2_q  <= 32'h0;
      cyc_q  <= 32'h0;
      errc_q <= 32'h0;
    end else begin
      if (out0_we) out0_q <= dmemreq_wdata;
      if (out1_we) out1_q <= dmemreq_wdata;
      if (out2_we) out2_q <= dmemreq_wdata;
      in0_q  <= in0;
      in1_q  <= in1;
      in2_q  <= in2;
      cyc_q  <= cyc_d;
      errc_q <= errc_d;
    end
  end

  // RAM contents survive reset; only the write itself is blocked by rst.
  always_ff @(posedge clk) begin
    if (ram_we && !rst)
      mem_q[dmemreq_addr[AW+1:2]] <= dmemreq_wdata;
  end

endmodule

// File: doc/proc_dmem_mmio_responder.md
Name: proc_dmem_mmio_responder

Overview:
- Responder end of the single-cycle processor's data-memory port (dmemreq_*/dmemresp_rdata); replaces the behavioural test memory on the data side for synthesizable builds.
- Decodes each request to either a word RAM region or a memory-mapped I/O region.
- MMIO region holds output registers out0..out2, input ports in0..in2, a cycle counter and an access-error counter.
- Reads are combinational (same cycle, as the single-cycle core requires); all state updates at posedge clk.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words; must be a power of two, at least 4.
- MMIO_BASE, 32'h0002_0000, byte base address of the MMIO region; 64-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dmemreq_val  in  1  request valid this cycle.
- dmemreq_type  in  1  0 = read, 1 = write.
- dmemreq_addr  in  32  byte address.
- dmemreq_wdata  in  32  store data.
- dmemresp_rdata  out  32  load data, combinational from the current request.
- dmemresp_err  out  1  combinational: current valid request is unaligned, unmapped, or a write to a read-only location.
- in0, in1, in2  in  32 each  external inputs.
- out0, out1, out2  out  32 each  output registers.

Behaviour:
- Reset (rst=1 at posedge): out0..out2=0, cycle_cnt=0, err_cnt=0, in-sample registers=0. RAM contents are not reset.
- dmemresp_rdata=0 and dmemresp_err=0 whenever dmemreq_val=0.
- Input sampling: in0..in2 are registered every cycle. A read returns the value sampled at the previous edge, giving 1-cycle pin-to-read latency.
- Alignment: if dmemreq_addr[1:0]!=0, the request is an error. Reads return 0; writes are ignored.
- RAM region: addr < RAM_WORDS*4, indexed by addr[log2(RAM_WORDS)+1:2].
  - Read returns the current word.
  - Write updates the word at the edge; the new value is visible from the next cycle.
- MMIO region, offsets from MMIO_BASE:
  - 0x00/0x04/0x08: out0/out1/out2. Read/write; a write loads wdata at the edge.
  - 0x10/0x14/0x18: in0/in1/in2 samples. Read-only; a write is an error and has no other effect.
  - 0x20: cycle_cnt. Read returns the current value. A write (any data) clears it: the value after that edge is 0, not 1. Not an error.
  - 0x24: err_cnt. Read returns the current value. A write (any data) clears it to 0; this overrides any simultaneous increment.
- Any other address is unmapped: read returns 0, write is ignored, error.
- cycle_cnt: increments by 1 every cycle not in reset; wraps 0xFFFF_FFFF -> 0.
- err_cnt:
  - Increments by 1 at the edge for each cycle with dmemreq_val=1 and dmemresp_err=1.
  - Saturates at 0xFFFF_FFFF.
  - Requests with val=0 never count, whatever the other inputs are.
- At most one request per cycle; no back-pressure; no ready signal.
- Reset asserted mid-run: rst takes priority over every write and counter update in that cycle.

Test Plan:
- Reset, then val=1, type=0, addr=MMIO_BASE+0x00 -> rdata=0, err=0. out0..out2=0, and cycle_cnt reads 0 in the first cycle after reset.
- Write RAM addr 0x0000_0010, data 0xDEAD_BEEF; next cycle read the same address -> 0xDEAD_BEEF. Read addr 0x0000_0014 -> unchanged value.
- Write 0x0000_00AB to MMIO_BASE+0x04 -> out1=0x0000_00AB after the edge. Read back the same address -> 0x0000_00AB.
- Set in2=0x1234_5678 at cycle k; read MMIO_BASE+0x18 at cycle k -> old sample, at cycle k+1 -> 0x1234_5678. Write MMIO_BASE+0x18 -> err=1, and err_cnt reads 1 next cycle.
- Sequence read 0x0000_0002 (unaligned), write MMIO_BASE+0x3C (unmapped), val=0 idle cycle -> both requests return rdata=0, err=1. err_cnt=2 afterwards; RAM and out registers unchanged.
- Write MMIO_BASE+0x20 at cycle n -> cycle_cnt=0 at n+1, 1 at n+2. Write MMIO_BASE+0x24 while err_cnt=2 -> 0. Assert rst during a write to out0 -> out0=0.
